// File: rtl/fpu_mult_arbiter.sv
// fpu_mult_arbiter: credit-gated two-requester arbiter for a shared fixed-latency FP multiply pipeline with per-requester result FIFOs
// Define FPU_MULT_ARB_PRIORITY_EN for strict priority to requester 0 instead of round-robin.
module fpu_mult_arbiter #(
   parameter int LATENCY      = 3,
   parameter int RESULT_DEPTH = 8,
   parameter int RESULT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   req_valid,
   output logic [1:0]                   req_ready,
   input  logic [1:0][31:0]             req_a,
   input  logic [1:0][31:0]             req_b,
   input  logic [1:0][2:0]              req_mode,
   output logic                         mul_valid,
   output logic [31:0]                  mul_a,
   output logic [31:0]                  mul_b,
   output logic [2:0]                   mul_mode,
   input  logic                         mul_result_valid,
   input  logic [RESULT_WIDTH-1:0]      mul_result,
   output logic [1:0]                   rsp_valid,
   input  logic [1:0]                   rsp_ready,
   output logic [1:0][RESULT_WIDTH-1:0] rsp_data,
   output logic                         mul_error
);
   localparam int AW = $clog2(RESULT_DEPTH);
   localparam int CW = AW + 1;
   logic [1:0] elig, ret_vec, push_vec, pop_vec;
   logic gnt_any, gnt_idx, mul_src;
   logic [LATENCY-1:0] tag_v, tag_s;
   logic [CW-1:0] fifo_count [2];
   logic [CW-1:0] inflight [2];
   logic [AW-1:0] wptr [2];
   logic [AW-1:0] rptr [2];
   logic [RESULT_WIDTH-1:0] mem [2][RESULT_DEPTH];
`ifndef FPU_MULT_ARB_PRIORITY_EN
   logic last;
`endif
   // eligibility comes only from registered occupancy, so a grant can never overrun a FIFO
   always_comb begin
      for (int i = 0; i < 2; i++)
         elig[i] = req_valid[i] && (int'(fifo_count[i]) + int'(inflight[i]) < RESULT_DEPTH);
      gnt_any = |elig;
`ifdef FPU_MULT_ARB_PRIORITY_EN
      gnt_idx = ~elig[0];
`else
      gnt_idx = &elig ? ~last : elig[1];
`endif
      req_ready = (rst && gnt_any) ? 2'b01 << gnt_idx : 2'b00;
   end
   // the tag pipe tail says which FIFO the current pipeline result belongs to
   always_comb begin
      ret_vec = tag_v[LATENCY-1] ? 2'b01 << tag_s[LATENCY-1] : 2'b00;
      push_vec = mul_result_valid ? ret_vec : 2'b00;
      for (int i = 0; i < 2; i++) begin
         rsp_valid[i] = fifo_count[i] != '0;
         rsp_data[i] = rsp_valid[i] ? mem[i][rptr[i]] : '0;
      end
      pop_vec = rsp_valid & rsp_ready;
   end
`ifndef FPU_MULT_ARB_PRIORITY_EN
   // remember the last winner so ties alternate; requester 0 wins the first tie
   always_ff @(posedge clk or negedge rst)
      if (!rst) last <= 1'b1;
      else if (gnt_any) last <= gnt_idx;
`endif
   // issue registers, tag pipe aligned to the pipeline latency, occupancy counters and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_valid <= 1'b0;
         mul_src <= 1'b0;
         mul_a <= '0;
         mul_b <= '0;
         mul_mode <= '0;
         tag_v <= '0;
         tag_s <= '0;
         mul_error <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_count[i] <= '0;
            inflight[i] <= '0;
            wptr[i] <= '0;
            rptr[i] <= '0;
         end
      end else begin
         mul_valid <= gnt_any;
         mul_src <= gnt_idx;
         if (gnt_any) begin
            mul_a <= req_a[gnt_idx];
            mul_b <= req_b[gnt_idx];
            mul_mode <= req_mode[gnt_idx];
         end
         tag_v <= LATENCY'({tag_v, mul_valid});
         tag_s <= LATENCY'({tag_s, mul_src});
         if (mul_result_valid != tag_v[LATENCY-1]) mul_error <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            inflight[i] <= inflight[i] + CW'(req_ready[i]) - CW'(ret_vec[i]);
            fifo_count[i] <= fifo_count[i] + CW'(push_vec[i]) - CW'(pop_vec[i]);
            wptr[i] <= wptr[i] + AW'(push_vec[i]);
            rptr[i] <= rptr[i] + AW'(pop_vec[i]);
         end
      end
   end
   // result storage needs no reset because rsp_data is masked while a FIFO is empty
   always_ff @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (push_vec[i]) mem[i][wptr[i]] <= mul_result;
endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// tb_fpu_mult_arbiter: directed stimulus, a behavioural pipeline stub, and a queue-based reference model checked every cycle
module tb_fpu_mult_arbiter;
   localparam int LAT = 3;
   localparam int DEPTH = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] rsp_ready = 2'b11;
   logic [1:0] req_ready, rsp_valid;
   logic [1:0][31:0] req_a = '0;
   logic [1:0][31:0] req_b = '0;
   logic [1:0][2:0] req_mode = '0;
   logic mul_valid, mul_error, mul_result_valid;
   logic [31:0] mul_a, mul_b, mul_result;
   logic [2:0] mul_mode;
   logic [1:0][31:0] rsp_data;
   logic orphan = 1'b0;
   logic lose = 1'b0;
   logic [LAT-1:0] pv;
   logic [31:0] pr [LAT];
   int checks = 0;
   int errors = 0;

   fpu_mult_arbiter #(.LATENCY(LAT), .RESULT_DEPTH(DEPTH), .RESULT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode),
      .mul_result_valid(mul_result_valid), .mul_result(mul_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mul_error(mul_error)
   );

   always #5 clk = ~clk;

   // truncating single-precision multiply for normal operands
   function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0] e;
      logic [22:0] m;
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'd1;
      end else m = p[45:23];
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
      end
   endtask

   // external pipeline: fixed latency, shares the reset, can drop one result or inject an orphan
   always @(posedge clk or negedge rst)
      if (!rst) begin
         pv <= '0;
         for (int k = 0; k < LAT; k++) pr[k] <= '0;
      end else begin
         pv <= {pv[LAT-2:0], mul_valid & ~lose};
         pr[0] <= fpmul(mul_a, mul_b);
         for (int k = 1; k < LAT; k++) pr[k] <= pr[k-1];
      end
   assign mul_result_valid = pv[LAT-1] | orphan;
   assign mul_result = pr[LAT-1];

   // reference model: queues of expected results, in-flight counts, credit arithmetic
   typedef struct { int due; int src; logic [31:0] val; } op_t;
   op_t m_pq[$];
   logic [31:0] m_fq[2][$];
   int m_infl[2] = '{0, 0};
   int m_cyc = 0;
   int m_s;
   logic m_err = 1'b0;
   logic m_mv = 1'b0;
   logic m_last = 1'b1;
   logic [31:0] m_ma = '0;
   logic [31:0] m_mb = '0;
   logic [2:0] m_mm = '0;
   logic [1:0] m_g;

   function automatic logic [1:0] model_ready();
      logic [1:0] el;
      for (int i = 0; i < 2; i++)
         el[i] = req_valid[i] && (DEPTH - m_fq[i].size() - m_infl[i] > 0);
      if (!rst || el == 2'b00) return 2'b00;
`ifdef FPU_MULT_ARB_PRIORITY_EN
      return el[0] ? 2'b01 : 2'b10;
`else
      if (el == 2'b11) return m_last ? 2'b01 : 2'b10;
      return el;
`endif
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_fq[0].delete();
         m_fq[1].delete();
         m_pq.delete();
         m_infl = '{0, 0};
         m_err = 1'b0;
         m_mv = 1'b0;
         m_last = 1'b1;
         m_ma = '0;
         m_mb = '0;
         m_mm = '0;
      end else begin
         m_g = model_ready();
         for (int i = 0; i < 2; i++)
            if (m_fq[i].size() != 0 && rsp_ready[i]) void'(m_fq[i].pop_front());
         if (m_pq.size() != 0 && m_pq[0].due == m_cyc) begin
            if (mul_result_valid) m_fq[m_pq[0].src].push_back(m_pq[0].val);
            else m_err = 1'b1;
            m_infl[m_pq[0].src]--;
            void'(m_pq.pop_front());
         end else if (mul_result_valid) m_err = 1'b1;
         m_mv = m_g != 2'b00;
         if (m_g != 2'b00) begin
            m_s = m_g[1] ? 1 : 0;
            m_ma = req_a[m_s];
            m_mb = req_b[m_s];
            m_mm = req_mode[m_s];
            m_pq.push_back('{m_cyc + 1 + LAT, m_s, fpmul(req_a[m_s], req_b[m_s])});
            m_infl[m_s]++;
            m_last = m_g[1];
         end
      end
      m_cyc++;
   end

   // compare DUT against the model away from the active edge
   always @(negedge clk) begin
      chk("req_ready", 32'(req_ready), 32'(model_ready()));
      chk("mul_valid", 32'(mul_valid), 32'(m_mv));
      chk("mul_a", mul_a, m_ma);
      chk("mul_b", mul_b, m_mb);
      chk("mul_mode", 32'(mul_mode), 32'(m_mm));
      chk("mul_error", 32'(mul_error), 32'(m_err));
      for (int i = 0; i < 2; i++) begin
         chk("rsp_valid", 32'(rsp_valid[i]), 32'(m_fq[i].size() != 0));
         chk("rsp_data", rsp_data[i], m_fq[i].size() != 0 ? m_fq[i][0] : 32'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [1:0] tie_exp [4];
   int hs;

   initial begin
`ifdef FPU_MULT_ARB_PRIORITY_EN
      tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      #1 rst = 1'b0;
      repeat (2) tick();
      req_valid = 2'b11;
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'h0);
      chk("reset_mul_valid", 32'(mul_valid), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_mul_error", 32'(mul_error), 32'h0);
      req_valid = 2'b00;
      rst = 1'b1;
      // tie from reset
      req_a = {32'h3FC00000, 32'h40000000};
      req_b = {32'h3FC00000, 32'h40400000};
      req_mode = {3'd2, 3'd1};
      for (int c = 0; c < 4; c++) begin
         tick();
         req_valid = 2'b11;
         #1 chk("tie_grant", 32'(req_ready), 32'(tie_exp[c]));
      end
      tick();
      req_valid = 2'b00;
      tick();
      #1;
      chk("tie_rsp0_valid", 32'(rsp_valid[0]), 32'h1);
      chk("tie_rsp0_data", rsp_data[0], 32'h40C00000);
      repeat (6) tick();
      // single op, latency LATENCY+2
      req_a[0] = 32'h40000000;
      req_b[0] = 32'h40400000;
      req_mode[0] = 3'd0;
      req_valid = 2'b01;
      #1 chk("single_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      #1;
      chk("single_mul_valid", 32'(mul_valid), 32'h1);
      chk("single_mul_a", mul_a, 32'h40000000);
      chk("single_mul_b", mul_b, 32'h40400000);
      repeat (3) tick();
      #1 chk("single_not_yet", 32'(rsp_valid), 32'h0);
      tick();
      #1;
      chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("single_rsp_data", rsp_data[0], 32'h40C00000);
      repeat (4) tick();
      // credit stall on requester 1
      rsp_ready = 2'b01;
      hs = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         req_valid = 2'b10;
         req_a[1] = 32'h3F800000 | (32'(c) << 19);
         req_b[1] = 32'h40000000;
         #1 if (req_valid[1] && req_ready[1]) hs++;
      end
      chk("stall_handshakes", 32'(hs), 32'd8);
      chk("stall_ready_low", 32'(req_ready[1]), 32'h0);
      chk("stall_fifo_full", 32'(rsp_valid[1]), 32'h1);
      tick();
      rsp_ready = 2'b11;
      #1 chk("stall_pop_cycle", 32'(req_ready[1]), 32'h0);
      tick();
      rsp_ready = 2'b01;
      #1 chk("stall_credit_back", 32'(req_ready[1]), 32'h1);
      tick();
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      repeat (14) tick();
      // orphan result
      orphan = 1'b1;
      tick();
      orphan = 1'b0;
      #1;
      chk("orphan_error", 32'(mul_error), 32'h1);
      chk("orphan_no_push", 32'(rsp_valid), 32'h0);
      repeat (3) tick();
      #1 chk("orphan_sticky", 32'(mul_error), 32'h1);
      // reset with operations in flight
      req_mode = {3'd5, 3'd3};
      for (int c = 0; c < 3; c++) begin
         tick();
         req_valid = 2'b11;
      end
      tick();
      req_valid = 2'b00;
      repeat (2) tick();
      #1 chk("pre_reset_rsp", 32'(rsp_valid), 32'h1);
      rst = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("mid_reset_req_ready", 32'(req_ready), 32'h0);
      chk("mid_reset_mul_valid", 32'(mul_valid), 32'h0);
      chk("mid_reset_mul_a", mul_a, 32'h0);
      chk("mid_reset_mul_mode", 32'(mul_mode), 32'h0);
      chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mid_reset_rsp_data", rsp_data[0] | rsp_data[1], 32'h0);
      chk("mid_reset_error", 32'(mul_error), 32'h0);
      tick();
      req_valid = 2'b00;
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         #1 chk("post_reset_quiet", 32'(rsp_valid), 32'h0);
      end
      chk("post_reset_error", 32'(mul_error), 32'h0);
      // lost result
      lose = 1'b1;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      repeat (6) tick();
      #1;
      chk("lost_error", 32'(mul_error), 32'h1);
      chk("lost_no_push", 32'(rsp_valid), 32'h0);
      lose = 1'b0;
      req_valid = 2'b01;
      #1 chk("lost_credit_back", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      repeat (8) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
